ahb_lite_arbiter2: RTL and testbench

- Two-master AHB-Lite interconnect arbiter in front of the single AHB_TOP slave. Shares the slave between master 0 (CPU side) and master 1 (DMA side).
- Address-phase signals of the granted master are muxed to the slave. Write data follows the data-phase owner. HRDATA, HREADY and HRESP are routed back to the correct master.
- Re-arbitrates only at transfer/burst boundaries. Honours HMASTLOCK.

---
 rtl/ahb_lite_arbiter2_pkg.sv | 32 +++
 rtl/ahb_lite_arbiter2_rr.sv | 23 ++
 rtl/ahb_lite_arbiter2.sv | 130 +++++++++++++
 tb/tb_ahb_lite_arbiter2.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_arbiter2_pkg.sv
// Shared AHB-Lite encodings for the two-master arbiter.
package ahb_lite_arbiter2_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_t;

  typedef enum logic {
    MASTER_0 = 1'b0,
    MASTER_1 = 1'b1
  } master_id_t;

endpackage

// File: rtl/ahb_lite_arbiter2_rr.sv
// Combinational two-way winner select: round-robin or fixed priority, parks on owner when idle.
module ahb_rr_arbiter2
  import ahb_lite_arbiter2_pkg::*;
#(
  parameter int ARB_MODE = 0
) (
  input  logic [1:0] req,
  input  master_id_t last_win,
  input  master_id_t cur_owner,
  output master_id_t winner
);

  always_comb begin
    winner = cur_owner;
    case (req)
      2'b01:   winner = MASTER_0;
      2'b10:   winner = MASTER_1;
      2'b11:   winner = (ARB_MODE == 1) ? MASTER_0 : master_id_t'(~last_win);
      default: winner = cur_owner;
    endcase
  end

endmodule

// File: rtl/ahb_lite_arbiter2.sv
// Two-master AHB-Lite arbiter: address-phase mux, data-phase routing, burst/lock-aware handover.
module ahb_lite_arbiter2
  import ahb_lite_arbiter2_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = 0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [ADDR_W-1:0] m0_HADDR,
  input  logic [1:0]        m0_HTRANS,
  input  logic              m0_HWRITE,
  input  logic [2:0]        m0_HSIZE,
  input  logic [2:0]        m0_HBURST,
  input  logic [3:0]        m0_HPROT,
  input  logic              m0_HMASTLOCK,
  input  logic [DATA_W-1:0] m0_HWDATA,
  output logic              m0_HREADY,
  output logic              m0_HRESP,
  output logic [DATA_W-1:0] m0_HRDATA,
  input  logic [ADDR_W-1:0] m1_HADDR,
  input  logic [1:0]        m1_HTRANS,
  input  logic              m1_HWRITE,
  input  logic [2:0]        m1_HSIZE,
  input  logic [2:0]        m1_HBURST,
  input  logic [3:0]        m1_HPROT,
  input  logic              m1_HMASTLOCK,
  input  logic [DATA_W-1:0] m1_HWDATA,
  output logic              m1_HREADY,
  output logic              m1_HRESP,
  output logic [DATA_W-1:0] m1_HRDATA,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic              HMASTLOCK,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  input  logic [DATA_W-1:0] HRDATA,
  output logic              grant
);

  master_id_t addr_owner_q, data_owner_q, last_win_q;
  master_id_t winner, grant_sel;
  logic       data_active_q;
  logic [1:0] req;
  logic [1:0] owner_trans;
  logic       owner_lock, arb_pt;
  logic [1:0] sel_trans;
  logic       sel_lock;

  function automatic logic master_ready(input master_id_t id, input master_id_t d_owner,
                                        input master_id_t g_sel, input logic requesting,
                                        input logic slave_ready);
    if (d_owner == id)   return slave_ready;
    else if (g_sel == id) return slave_ready;
    else if (requesting) return 1'b0;
    else                 return 1'b1;
  endfunction

  assign req = {m1_HTRANS == HTRANS_NONSEQ, m0_HTRANS == HTRANS_NONSEQ};

  assign owner_trans = (addr_owner_q == MASTER_1) ? m1_HTRANS    : m0_HTRANS;
  assign owner_lock  = (addr_owner_q == MASTER_1) ? m1_HMASTLOCK : m0_HMASTLOCK;

  // SEQ/BUSY or a held lock keep the current owner mid-burst
  assign arb_pt = ((owner_trans == HTRANS_IDLE) || (owner_trans == HTRANS_NONSEQ)) && !owner_lock;

  ahb_rr_arbiter2 #(.ARB_MODE(ARB_MODE)) u_arb (
    .req       (req),
    .last_win  (last_win_q),
    .cur_owner (addr_owner_q),
    .winner    (winner)
  );

  assign grant_sel = arb_pt ? winner : addr_owner_q;
  assign grant     = addr_owner_q;

  always_comb begin
    if (grant_sel == MASTER_1) begin
      HADDR     = m1_HADDR;
      sel_trans = m1_HTRANS;
      HWRITE    = m1_HWRITE;
      HSIZE     = m1_HSIZE;
      HBURST    = m1_HBURST;
      HPROT     = m1_HPROT;
      sel_lock  = m1_HMASTLOCK;
    end else begin
      HADDR     = m0_HADDR;
      sel_trans = m0_HTRANS;
      HWRITE    = m0_HWRITE;
      HSIZE     = m0_HSIZE;
      HBURST    = m0_HBURST;
      HPROT     = m0_HPROT;
      sel_lock  = m0_HMASTLOCK;
    end
  end

  assign HTRANS    = HRESETn ? sel_trans : HTRANS_IDLE;
  assign HMASTLOCK = HRESETn & sel_lock;
  assign HWDATA    = (data_owner_q == MASTER_1) ? m1_HWDATA : m0_HWDATA;

  assign m0_HREADY = !HRESETn || master_ready(MASTER_0, data_owner_q, grant_sel, req[0], HREADY);
  assign m1_HREADY = !HRESETn || master_ready(MASTER_1, data_owner_q, grant_sel, req[1], HREADY);

  assign m0_HRESP  = (data_active_q && data_owner_q == MASTER_0) ? HRESP : HRESP_OKAY;
  assign m1_HRESP  = (data_active_q && data_owner_q == MASTER_1) ? HRESP : HRESP_OKAY;
  assign m0_HRDATA = HRDATA;
  assign m1_HRDATA = HRDATA;

  // Address phase advances into data phase only on a ready edge
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_owner_q  <= MASTER_0;
      data_owner_q  <= MASTER_0;
      data_active_q <= 1'b0;
      last_win_q    <= MASTER_1;
    end else if (HREADY) begin
      addr_owner_q  <= grant_sel;
      data_owner_q  <= grant_sel;
      data_active_q <= HTRANS[1];
      if (arb_pt && (&req)) last_win_q <= winner;
    end
  end

endmodule

// File: tb/tb_ahb_lite_arbiter2.sv
// Directed bench for ahb_lite_arbiter2 (round-robin mode).
module tb_ahb_lite_arbiter2;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] m0_HADDR, m1_HADDR;
  logic [1:0]  m0_HTRANS, m1_HTRANS;
  logic        m0_HWRITE, m1_HWRITE;
  logic [2:0]  m0_HSIZE, m1_HSIZE;
  logic [2:0]  m0_HBURST, m1_HBURST;
  logic [3:0]  m0_HPROT, m1_HPROT;
  logic        m0_HMASTLOCK, m1_HMASTLOCK;
  logic [31:0] m0_HWDATA, m1_HWDATA;
  logic        m0_HREADY, m1_HREADY;
  logic        m0_HRESP, m1_HRESP;
  logic [31:0] m0_HRDATA, m1_HRDATA;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        grant;

  int nvec = 0;
  int nerr = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_arbiter2 #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(0)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m0_HADDR(m0_HADDR), .m0_HTRANS(m0_HTRANS), .m0_HWRITE(m0_HWRITE), .m0_HSIZE(m0_HSIZE),
    .m0_HBURST(m0_HBURST), .m0_HPROT(m0_HPROT), .m0_HMASTLOCK(m0_HMASTLOCK), .m0_HWDATA(m0_HWDATA),
    .m0_HREADY(m0_HREADY), .m0_HRESP(m0_HRESP), .m0_HRDATA(m0_HRDATA),
    .m1_HADDR(m1_HADDR), .m1_HTRANS(m1_HTRANS), .m1_HWRITE(m1_HWRITE), .m1_HSIZE(m1_HSIZE),
    .m1_HBURST(m1_HBURST), .m1_HPROT(m1_HPROT), .m1_HMASTLOCK(m1_HMASTLOCK), .m1_HWDATA(m1_HWDATA),
    .m1_HREADY(m1_HREADY), .m1_HRESP(m1_HRESP), .m1_HRDATA(m1_HRDATA),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA), .grant(grant)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set0(input logic [1:0] t, input logic [31:0] a, input logic w,
                      input logic l, input logic [2:0] b);
    m0_HTRANS = t; m0_HADDR = a; m0_HWRITE = w; m0_HMASTLOCK = l; m0_HBURST = b;
  endtask

  task automatic set1(input logic [1:0] t, input logic [31:0] a, input logic w,
                      input logic l, input logic [2:0] b);
    m1_HTRANS = t; m1_HADDR = a; m1_HWRITE = w; m1_HMASTLOCK = l; m1_HBURST = b;
  endtask

  initial begin
    HRESETn = 1'b0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    m0_HSIZE = 3'd2; m0_HPROT = 4'h3; m0_HWDATA = 32'h0;
    m1_HSIZE = 3'd1; m1_HPROT = 4'hA; m1_HWDATA = 32'h0;
    set0(2'b00, 32'h0, 1'b0, 1'b0, 3'd0);
    set1(2'b00, 32'h0, 1'b0, 1'b0, 3'd0);
    tick(); tick();

    // reset state with a master trying to drive a locked NONSEQ and the slave stalling
    set0(2'b10, 32'h40, 1'b1, 1'b1, 3'd0);
    HREADY = 1'b0;
    #1;
    chk("rst_htrans",    64'(HTRANS), 64'h0);
    chk("rst_lock",      64'(HMASTLOCK), 64'h0);
    chk("rst_grant",     64'(grant), 64'h0);
    chk("rst_m0_hready", 64'(m0_HREADY), 64'h1);
    chk("rst_m1_hready", 64'(m1_HREADY), 64'h1);
    chk("rst_m0_hresp",  64'(m0_HRESP), 64'h0);
    HRESETn = 1'b1;
    HREADY = 1'b1;
    set0(2'b00, 32'h0, 1'b0, 1'b0, 3'd0);
    tick();

    // single master write
    set0(2'b10, 32'h100, 1'b1, 1'b0, 3'd0);
    #1;
    chk("s_haddr",  64'(HADDR), 64'h100);
    chk("s_htrans", 64'(HTRANS), 64'h2);
    chk("s_hwrite", 64'(HWRITE), 64'h1);
    chk("s_hsize",  64'(HSIZE), 64'h2);
    chk("s_hprot",  64'(HPROT), 64'h3);
    chk("s_m1_rdy", 64'(m1_HREADY), 64'h1);
    tick();
    set0(2'b00, 32'h0, 1'b0, 1'b0, 3'd0);
    m0_HWDATA = 32'hA5A5_0100;
    #1;
    chk("s_hwdata",  64'(HWDATA), 64'hA5A5_0100);
    chk("s_m0_rdy1", 64'(m0_HREADY), 64'h1);
    HREADY = 1'b0;
    #1;
    chk("s_m0_rdy0", 64'(m0_HREADY), 64'h0);
    chk("s_m1_rdyw", 64'(m1_HREADY), 64'h1);
    HREADY = 1'b1;
    tick();

    // simultaneous requests: m0 first, m1 next; next tie goes to m1
    set0(2'b10, 32'h200, 1'b1, 1'b0, 3'd0);
    set1(2'b10, 32'h300, 1'b0, 1'b0, 3'd0);
    #1;
    chk("t1_haddr",  64'(HADDR), 64'h200);
    chk("t1_m1_rdy", 64'(m1_HREADY), 64'h0);
    chk("t1_m0_rdy", 64'(m0_HREADY), 64'h1);
    tick();
    set0(2'b00, 32'h0, 1'b0, 1'b0, 3'd0);
    #1;
    chk("t1_hand_haddr", 64'(HADDR), 64'h300);
    chk("t1_hand_m1rdy", 64'(m1_HREADY), 64'h1);
    chk("t1_hand_hsize", 64'(HSIZE), 64'h1);
    tick();
    set0(2'b10, 32'h400, 1'b1, 1'b0, 3'd0);
    set1(2'b10, 32'h500, 1'b0, 1'b0, 3'd0);
    #1;
    chk("t2_grant",  64'(grant), 64'h1);
    chk("t2_haddr",  64'(HADDR), 64'h500);
    chk("t2_m0_rdy", 64'(m0_HREADY), 64'h0);
    tick();
    set1(2'b00, 32'h0, 1'b0, 1'b0, 3'd0);
    #1;
    chk("t2_m0_haddr", 64'(HADDR), 64'h400);
    chk("t2_m0_rdy1",  64'(m0_HREADY), 64'h1);
    tick();
    set0(2'b00, 32'h0, 1'b0, 1'b0, 3'd0);
    tick();

    // INCR4 from m0 with m1 arriving at beat 3
    set0(2'b10, 32'h1000, 1'b1, 1'b0, 3'd3);
    #1;
    chk("b_hburst", 64'(HBURST), 64'h3);
    tick();
    set0(2'b11, 32'h1004, 1'b1, 1'b0, 3'd3);
    tick();
    set0(2'b11, 32'h1008, 1'b1, 1'b0, 3'd3);
    set1(2'b10, 32'h2000, 1'b0, 1'b0, 3'd0);
    #1;
    chk("b3_haddr",  64'(HADDR), 64'h1008);
    chk("b3_m1_rdy", 64'(m1_HREADY), 64'h0);
    tick();
    set0(2'b11, 32'h100C, 1'b1, 1'b0, 3'd3);
    #1;
    chk("b4_htrans", 64'(HTRANS), 64'h3);
    chk("b4_haddr",  64'(HADDR), 64'h100C);
    chk("b4_m1_rdy", 64'(m1_HREADY), 64'h0);
    tick();
    set0(2'b00, 32'h0, 1'b0, 1'b0, 3'd0);
    #1;
    chk("b_m1_htrans", 64'(HTRANS), 64'h2);
    chk("b_m1_haddr",  64'(HADDR), 64'h2000);
    chk("b_m1_rdy",    64'(m1_HREADY), 64'h1);
    tick();
    set1(2'b00, 32'h0, 1'b0, 1'b0, 3'd0);
    tick();

    // locked m0 over two bursts
    set0(2'b10, 32'h8000, 1'b1, 1'b1, 3'd1);
    #1;
    chk("l_haddr", 64'(HADDR), 64'h8000);
    chk("l_lock",  64'(HMASTLOCK), 64'h1);
    tick();
    set0(2'b11, 32'h8004, 1'b1, 1'b1, 3'd1);
    set1(2'b10, 32'h3000, 1'b0, 1'b0, 3'd0);
    #1;
    chk("l_seq_m1_rdy", 64'(m1_HREADY), 64'h0);
    tick();
    set0(2'b10, 32'h8100, 1'b1, 1'b1, 3'd1);
    #1;
    chk("l_b2_haddr",  64'(HADDR), 64'h8100);
    chk("l_b2_m1_rdy", 64'(m1_HREADY), 64'h0);
    chk("l_b2_lock",   64'(HMASTLOCK), 64'h1);
    tick();
    set0(2'b00, 32'h0, 1'b0, 1'b0, 3'd0);
    #1;
    chk("l_rel_htrans", 64'(HTRANS), 64'h2);
    chk("l_rel_haddr",  64'(HADDR), 64'h3000);
    chk("l_rel_lock",   64'(HMASTLOCK), 64'h0);
    chk("l_rel_m1_rdy", 64'(m1_HREADY), 64'h1);
    tick();
    set1(2'b00, 32'h0, 1'b0, 1'b0, 3'd0);
    tick();

    // wait states on m0 write data phase with m1 pending
    set0(2'b10, 32'h4000, 1'b1, 1'b0, 3'd0);
    tick();
    set0(2'b00, 32'h0, 1'b0, 1'b0, 3'd0);
    m0_HWDATA = 32'hCAFE_0001;
    set1(2'b10, 32'h5000, 1'b0, 1'b0, 3'd0);
    HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("w_grant",  64'(grant), 64'h0);
      chk("w_hwdata", 64'(HWDATA), 64'hCAFE_0001);
      chk("w_m1_rdy", 64'(m1_HREADY), 64'h0);
      chk("w_m0_rdy", 64'(m0_HREADY), 64'h0);
      if (i < 2) tick();
    end
    HREADY = 1'b1;
    #1;
    chk("w_end_m1_rdy", 64'(m1_HREADY), 64'h1);
    chk("w_end_haddr",  64'(HADDR), 64'h5000);
    tick();
    set1(2'b00, 32'h0, 1'b0, 1'b0, 3'd0);
    #1;
    chk("w_grant1", 64'(grant), 64'h1);

    // two-cycle ERROR on m1 read, read data broadcast
    HREADY = 1'b0; HRESP = 1'b1; HRDATA = 32'h1234_5678;
    #1;
    chk("e1_m1_resp",  64'(m1_HRESP), 64'h1);
    chk("e1_m0_resp",  64'(m0_HRESP), 64'h0);
    chk("e1_m1_rdy",   64'(m1_HREADY), 64'h0);
    chk("e1_m0_rdy",   64'(m0_HREADY), 64'h1);
    chk("e1_m0_rdata", 64'(m0_HRDATA), 64'h1234_5678);
    chk("e1_m1_rdata", 64'(m1_HRDATA), 64'h1234_5678);
    tick();
    HREADY = 1'b1;
    #1;
    chk("e2_m1_resp", 64'(m1_HRESP), 64'h1);
    chk("e2_m0_resp", 64'(m0_HRESP), 64'h0);
    chk("e2_m1_rdy",  64'(m1_HREADY), 64'h1);
    tick();
    HRESP = 1'b0;

    // reset in the middle of an m1 burst
    set1(2'b10, 32'h6000, 1'b0, 1'b1, 3'd3);
    tick();
    set1(2'b11, 32'h6004, 1'b0, 1'b1, 3'd3);
    set0(2'b10, 32'h7000, 1'b1, 1'b0, 3'd0);
    HRESP = 1'b1;
    #1;
    chk("r_pre_grant",  64'(grant), 64'h1);
    chk("r_pre_m0_rdy", 64'(m0_HREADY), 64'h0);
    chk("r_pre_m1_rsp", 64'(m1_HRESP), 64'h1);
    HRESETn = 1'b0;
    #1;
    chk("r_grant",   64'(grant), 64'h0);
    chk("r_htrans",  64'(HTRANS), 64'h0);
    chk("r_lock",    64'(HMASTLOCK), 64'h0);
    chk("r_m0_rdy",  64'(m0_HREADY), 64'h1);
    chk("r_m1_rdy",  64'(m1_HREADY), 64'h1);
    chk("r_m1_resp", 64'(m1_HRESP), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
